// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ctrl
//  Brief    : Load/store unit controller. Accepts one RISC-V style access at a
//             time, issues a single aligned memory beat with byte mask, waits
//             for the memory response and returns extended load data or an
//             error (misaligned, illegal size code, or timeout).
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [2:0]                req_fun3,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_err,
  output logic [1:0]                resp_cause,
  output logic                      mem_req,
  input  logic                      mem_gnt,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH/8-1:0]   mem_wmask,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_MISAL = 2'b01;
  localparam logic [1:0] C_ILLEG = 2'b10;
  localparam logic [1:0] C_TMO   = 2'b11;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  we_q;
  logic [2:0]            fun3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [1:0]            cause_q;

  logic                  acc_illegal;
  logic                  acc_misal;
  logic                  accept;
  logic                  acc_err;
  logic                  rsp_ok;
  logic                  tmo;
  logic [LB-1:0]         lane;
  logic [LB+2:0]         bit_shift;
  logic [NB-1:0]         size_mask;
  logic [DATA_WIDTH-1:0] ld_shift;
  logic [DATA_WIDTH-1:0] ld_mask;
  logic                  ld_sign;
  logic [DATA_WIDTH-1:0] ld_ext;

  // Classify the incoming request: legal size code for this bus width, natural alignment
  always_comb begin
    acc_illegal = 1'b1;
    case (req_fun3)
      3'b000, 3'b001, 3'b010: acc_illegal = 1'b0;
      3'b011:                 acc_illegal = (DATA_WIDTH != 64);
      3'b100, 3'b101:         acc_illegal = req_we;
      3'b110:                 acc_illegal = req_we || (DATA_WIDTH != 64);
      default:                acc_illegal = 1'b1;
    endcase
    acc_misal = 1'b0;
    case (req_fun3[1:0])
      2'b00:   acc_misal = 1'b0;
      2'b01:   acc_misal = req_addr[0];
      2'b10:   acc_misal = |req_addr[1:0];
      default: acc_misal = |req_addr[2:0];
    endcase
  end

  assign accept  = (state == S_IDLE) && req_valid;
  assign acc_err = acc_illegal || acc_misal;
  // A response arriving on the last budgeted cycle still counts as success.
  assign rsp_ok  = (state == S_WAIT) && mem_rvalid;
  assign tmo     = ((state == S_REQ) || (state == S_WAIT)) && (cnt == CNT_LAST) && !rsp_ok;

  assign lane      = addr_q[LB-1:0];
  assign bit_shift = {lane, 3'b000};

  // Byte-lane mask for the access size and load-data alignment/extension
  always_comb begin
    size_mask = '0;
    ld_mask   = '1;
    ld_shift  = mem_rdata >> bit_shift;
    ld_sign   = 1'b0;
    case (fun3_q[1:0])
      2'b00: begin
        size_mask = NB'(8'h01);
        ld_mask   = DATA_WIDTH'(8'hFF);
        ld_sign   = ld_shift[7];
      end
      2'b01: begin
        size_mask = NB'(8'h03);
        ld_mask   = DATA_WIDTH'(16'hFFFF);
        ld_sign   = ld_shift[15];
      end
      2'b10: begin
        size_mask = NB'(8'h0F);
        ld_mask   = DATA_WIDTH'(32'hFFFF_FFFF);
        ld_sign   = ld_shift[31];
      end
      default: begin
        size_mask = NB'(8'hFF);
        ld_mask   = '1;
        ld_sign   = 1'b0;
      end
    endcase
    if (fun3_q[2]) begin
      ld_sign = 1'b0;
    end
    ld_ext = (ld_shift & ld_mask) | (ld_sign ? ~ld_mask : '0);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decision
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_nxt = acc_err ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (tmo) begin
          state_nxt = S_RESP;
        end else if (mem_gnt) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_ok || tmo) begin
          state_nxt = S_RESP;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture the request fields at accept time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      fun3_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      fun3_q  <= req_fun3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Cycle budget counter for the REQ+WAIT phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if ((state == S_REQ) || (state == S_WAIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Response registers: set by accept-time errors, timeout or memory response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      cause_q <= C_NONE;
    end else if (accept) begin
      rdata_q <= '0;
      err_q   <= acc_err;
      cause_q <= acc_illegal ? C_ILLEG : (acc_misal ? C_MISAL : C_NONE);
    end else if (rsp_ok) begin
      rdata_q <= we_q ? '0 : ld_ext;
      err_q   <= 1'b0;
      cause_q <= C_NONE;
    end else if (tmo) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
      cause_q <= C_TMO;
    end
  end

  // Outputs decoded from the current state; everything idles at zero
  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
    resp_rdata = (state == S_RESP) ? rdata_q : '0;
    resp_err   = (state == S_RESP) ? err_q : 1'b0;
    resp_cause = (state == S_RESP) ? cause_q : C_NONE;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wmask  = '0;
    mem_wdata  = '0;
    if (state == S_REQ) begin
      mem_req  = 1'b1;
      mem_we   = we_q;
      mem_addr = {addr_q[ADDR_WIDTH-1:LB], {LB{1'b0}}};
      if (we_q) begin
        mem_wmask = size_mask << lane;
        mem_wdata = wdata_q << bit_shift;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_ctrl
//  Brief    : Self-checking bench for lsu_ctrl: directed vector table,
//             randomized accesses against a behavioural model, and
//             hand-written reset/timeout/64-bit sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

  localparam int TA = 16;

  typedef struct {
    logic        we;
    logic [2:0]  fun3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic        err;
    logic [1:0]  cause;
    logic [31:0] rdata;
    logic [31:0] maddr;
    logic [3:0]  wmask;
    logic [31:0] mwdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;

  // 32-bit instance
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_fun3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_cause;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  // 64-bit instance with a short timeout
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [2:0]  b_req_fun3;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata;
  logic        b_resp_valid, b_resp_err;
  logic [63:0] b_resp_rdata;
  logic [1:0]  b_resp_cause;
  logic        b_mem_req, b_mem_gnt, b_mem_we, b_mem_rvalid;
  logic [31:0] b_mem_addr;
  logic [63:0] b_mem_wdata, b_mem_rdata;
  logic [7:0]  b_mem_wmask;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TA)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_cause(resp_cause),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  lsu_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(4)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_fun3(b_req_fun3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .resp_cause(b_resp_cause),
    .mem_req(b_mem_req), .mem_gnt(b_mem_gnt), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wmask(b_mem_wmask), .mem_wdata(b_mem_wdata), .mem_rvalid(b_mem_rvalid),
    .mem_rdata(b_mem_rdata)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] mr, input logic err,
                              input logic [1:0] c, input logic [31:0] rd, input logic [31:0] ma,
                              input logic [3:0] wm, input logic [31:0] mwd);
    vec_t v;
    v.we = we; v.fun3 = f3; v.addr = a; v.wdata = wd; v.mrdata = mr;
    v.err = err; v.cause = c; v.rdata = rd; v.maddr = ma; v.wmask = wm; v.mwdata = mwd;
    return v;
  endfunction

  // Reference model for a 32-bit bus, straight from the access rules
  function automatic vec_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] mrdata);
    vec_t e;
    int size, lane;
    bit legal, mis;
    longint unsigned val, lim;
    size  = 1 << f3[1:0];
    lane  = int'(addr % 32'd4);
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = (addr % 32'(size)) != 32'd0;
    e.we = we; e.fun3 = f3; e.addr = addr; e.wdata = wdata; e.mrdata = mrdata;
    e.err   = !legal || mis;
    e.cause = !legal ? 2'd2 : (mis ? 2'd1 : 2'd0);
    e.maddr = addr - 32'(lane);
    e.wmask = we ? 4'(((1 << size) - 1) << lane) : 4'd0;
    e.mwdata = we ? 32'(64'(wdata) << (8 * lane)) : 32'd0;
    lim = 64'd1 << (8 * size);
    val = (64'(mrdata) >> (8 * lane)) & (lim - 64'd1);
    if (!f3[2] && size < 8 && val >= (lim >> 1)) val = val | ~(lim - 64'd1);
    e.rdata = (we || e.err) ? 32'd0 : 32'(val);
    return e;
  endfunction

  // Issue one access on the 32-bit instance and play the memory side
  task automatic run_txn(input vec_t v, input int gd, input int rd, input bit nognt, input string tag);
    int cyc, reqc, wc, exp_lat, exp_reqc;
    bit gnt_given, done, tmo_case;
    logic        e_err;
    logic [1:0]  e_cause;
    logic [31:0] e_rdata;
    tmo_case = nognt && !v.err;
    e_err    = tmo_case ? 1'b1 : v.err;
    e_cause  = tmo_case ? 2'd3 : v.cause;
    e_rdata  = tmo_case ? 32'd0 : v.rdata;
    exp_lat  = v.err ? 1 : (tmo_case ? TA + 1 : gd + rd + 2);
    exp_reqc = v.err ? 0 : (tmo_case ? TA : gd + 1);
    @(negedge clk);
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = v.we; req_fun3 = v.fun3; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    cyc = 0; reqc = 0; wc = 0; gnt_given = 1'b0; done = 1'b0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      req_valid  = 1'b0;
      req_addr   = $urandom;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (resp_valid) begin
        done = 1'b1;
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_reqcycles"}, 64'(reqc), 64'(exp_reqc));
        chk({tag, "_err"}, 64'(resp_err), 64'(e_err));
        chk({tag, "_cause"}, 64'(resp_cause), 64'(e_cause));
        chk({tag, "_rdata"}, 64'(resp_rdata), 64'(e_rdata));
      end else if (mem_req) begin
        reqc++;
        if (reqc == 1) begin
          chk({tag, "_maddr"}, 64'(mem_addr), 64'(v.maddr));
          chk({tag, "_mwe"}, 64'(mem_we), 64'(v.we));
          chk({tag, "_wmask"}, 64'(mem_wmask), 64'(v.wmask));
          if (v.we) chk({tag, "_mwdata"}, 64'(mem_wdata), 64'(v.mwdata));
        end
        if (!nognt && reqc == gd + 1) begin
          mem_gnt   = 1'b1;
          gnt_given = 1'b1;
        end else begin
          mem_rvalid = 1'($urandom % 2);
        end
      end else begin
        chk({tag, "_memidle"}, {60'd0, mem_we, |mem_addr, |mem_wmask, |mem_wdata}, 64'd0);
        if (gnt_given) wc++;
        if (gnt_given && wc == rd) begin
          mem_rvalid = 1'b1;
          mem_rdata  = v.mrdata;
        end else begin
          mem_gnt = 1'($urandom % 2);
        end
      end
    end
    if (!done) chk({tag, "_noresp"}, 64'd0, 64'd1);
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk({tag, "_pulse"}, 64'(resp_valid), 64'd0);
    chk({tag, "_backidle"}, 64'(req_ready), 64'd1);
  endtask

  // Legal access on the 64-bit instance: grant at once, respond next cycle
  task automatic run_b(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [63:0] wd, input logic [63:0] mr, input logic [31:0] ema,
                       input logic [7:0] ewm, input logic [63:0] ewd, input logic [63:0] erd,
                       input string tag);
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = we; b_req_fun3 = f3; b_req_addr = a; b_req_wdata = wd;
    @(negedge clk);
    b_req_valid = 1'b0;
    chk({tag, "_mreq"}, 64'(b_mem_req), 64'd1);
    chk({tag, "_maddr"}, 64'(b_mem_addr), 64'(ema));
    chk({tag, "_wmask"}, 64'(b_mem_wmask), 64'(ewm));
    if (we) chk({tag, "_mwdata"}, b_mem_wdata, ewd);
    b_mem_gnt = 1'b1;
    @(negedge clk);
    b_mem_gnt = 1'b0;
    chk({tag, "_mreqoff"}, 64'(b_mem_req), 64'd0);
    b_mem_rvalid = 1'b1; b_mem_rdata = mr;
    @(negedge clk);
    b_mem_rvalid = 1'b0;
    chk({tag, "_rv"}, 64'(b_resp_valid), 64'd1);
    chk({tag, "_rdata"}, b_resp_rdata, erd);
    chk({tag, "_err"}, {b_resp_err, b_resp_cause}, 64'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(b_resp_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=stuck required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[14];
    vec_t v;
    int cnt;
    bit saw;

    tbl[0]  = mk(1, 3'b000, 32'h103, 32'hAB,        32'h0,         0, 2'd0, 32'h0,         32'h100, 4'b1000, 32'hAB00_0000);
    tbl[1]  = mk(0, 3'b001, 32'h102, 32'h0,         32'h8001_1234, 0, 2'd0, 32'hFFFF_8001, 32'h100, 4'b0000, 32'h0);
    tbl[2]  = mk(0, 3'b101, 32'h102, 32'h0,         32'h8001_1234, 0, 2'd0, 32'h0000_8001, 32'h100, 4'b0000, 32'h0);
    tbl[3]  = mk(0, 3'b010, 32'h101, 32'h0,         32'h0,         1, 2'd1, 32'h0,         32'h0,   4'b0000, 32'h0);
    tbl[4]  = mk(0, 3'b011, 32'h100, 32'h0,         32'h0,         1, 2'd2, 32'h0,         32'h0,   4'b0000, 32'h0);
    tbl[5]  = mk(1, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h5555_5555, 0, 2'd0, 32'h0,         32'h104, 4'b1111, 32'hDEAD_BEEF);
    tbl[6]  = mk(1, 3'b001, 32'h106, 32'h1234_5678, 32'h0,         0, 2'd0, 32'h0,         32'h104, 4'b1100, 32'h5678_0000);
    tbl[7]  = mk(0, 3'b000, 32'h101, 32'h0,         32'h0000_8000, 0, 2'd0, 32'hFFFF_FF80, 32'h100, 4'b0000, 32'h0);
    tbl[8]  = mk(0, 3'b100, 32'h103, 32'h0,         32'hF500_0000, 0, 2'd0, 32'h0000_00F5, 32'h100, 4'b0000, 32'h0);
    tbl[9]  = mk(1, 3'b100, 32'h200, 32'h0,         32'h0,         1, 2'd2, 32'h0,         32'h0,   4'b0000, 32'h0);
    tbl[10] = mk(0, 3'b110, 32'h101, 32'h0,         32'h0,         1, 2'd2, 32'h0,         32'h0,   4'b0000, 32'h0);
    tbl[11] = mk(1, 3'b001, 32'h101, 32'h0,         32'h0,         1, 2'd1, 32'h0,         32'h0,   4'b0000, 32'h0);
    tbl[12] = mk(0, 3'b010, 32'h108, 32'h0,         32'h1234_5678, 0, 2'd0, 32'h1234_5678, 32'h108, 4'b0000, 32'h0);
    tbl[13] = mk(1, 3'b111, 32'h300, 32'h0,         32'h0,         1, 2'd2, 32'h0,         32'h0,   4'b0000, 32'h0);

    rst_n = 1'b0;
    req_valid = 0; req_we = 0; req_fun3 = 0; req_addr = 0; req_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    b_req_valid = 0; b_req_we = 0; b_req_fun3 = 0; b_req_addr = 0; b_req_wdata = 0;
    b_mem_gnt = 0; b_mem_rvalid = 0; b_mem_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_outs", {59'd0, resp_valid, resp_err, |resp_rdata, |resp_cause, mem_req}, 64'd0);
    chk("rst_mem", {60'd0, mem_we, |mem_addr, |mem_wmask, |mem_wdata}, 64'd0);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      run_txn(tbl[i], i % 3, 1 + (i % 2), 1'b0, $sformatf("vec%0d", i));
    end

    // Timeout on the 32-bit instance
    run_txn(tbl[12], 0, 1, 1'b1, "tmo32");

    // Randomized accesses against the model
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom % 2 == 0) a = a & ~32'h7;
      v = model(1'($urandom % 2), 3'($urandom % 8), a, $urandom, $urandom);
      run_txn(v, int'($urandom % 4), 1 + int'($urandom % 3), ($urandom % 12) == 0,
              $sformatf("rnd%0d", i));
    end

    // Reset while waiting for read data
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_fun3 = 3'b010; req_addr = 32'h20;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstw_mreq", 64'(mem_req), 64'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rstw_inwait", 64'(req_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_ready", 64'(req_ready), 64'd1);
    chk("rstw_outs", {59'd0, resp_valid, resp_err, |resp_rdata, |resp_cause, mem_req}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (resp_valid) saw = 1'b1;
    end
    chk("rstw_norsp", 64'(saw), 64'd0);
    chk("rstw_idle", 64'(req_ready), 64'd1);

    // Reset while the memory request is outstanding
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_fun3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstq_mreq", 64'(mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstq_mem", {59'd0, mem_req, mem_we, |mem_addr, |mem_wmask, |mem_wdata}, 64'd0);
    chk("rstq_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 64-bit bus: whole-word load and an upper-lane store
    run_b(1'b0, 3'b011, 32'h8, 64'h0, 64'h8765_4321_DEAD_BEEF, 32'h8, 8'h00,
          64'h0, 64'h8765_4321_DEAD_BEEF, "ld64");
    run_b(1'b1, 3'b010, 32'hC, 64'hCAFE_BABE, 64'h0, 32'h8, 8'hF0,
          64'hCAFE_BABE_0000_0000, 64'h0, "sw64");
    run_b(1'b0, 3'b110, 32'h14, 64'h0, 64'h8000_0000_0000_0000, 32'h10, 8'h00,
          64'h0, 64'h0000_0000_8000_0000, "lwu64");

    // 64-bit instance, TIMEOUT=4: grant never comes
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_fun3 = 3'b010; b_req_addr = 32'h10;
    cnt = 0; saw = 1'b0;
    for (int k = 0; k < 20 && !saw; k++) begin
      @(negedge clk);
      b_req_valid = 1'b0;
      if (b_resp_valid) begin
        saw = 1'b1;
        chk("tmo_err", 64'(b_resp_err), 64'd1);
        chk("tmo_cause", 64'(b_resp_cause), 64'd3);
        chk("tmo_rdata", b_resp_rdata, 64'd0);
      end else if (b_mem_req) begin
        cnt++;
      end
    end
    chk("tmo_seen", 64'(saw), 64'd1);
    chk("tmo_reqcycles", 64'(cnt), 64'd4);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (b_mem_req || b_resp_valid) cnt++;
    end
    chk("tmo_quiet", 64'(cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
